// File: rtl/storage_copy_pkg.sv
// rtl/storage_copy_pkg.sv - shared states and constants for the Wishbone block-copy initiator
package storage_copy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    GAP_R = 3'd2,
    WR    = 3'd3,
    GAP_W = 3'd4
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0]  SEL_ALL    = 4'hF;

endpackage

// File: rtl/storage_copy_timer.sv
// rtl/storage_copy_timer.sv - ack watchdog: counts consecutive unacked strobe cycles
module storage_copy_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expired means the current cycle is the TIMEOUT_CYCLES-th strobe cycle without ack
  assign expired_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // count while strobing without ack; any ack or gap restarts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/storage_copy_wb.sv
// rtl/storage_copy_wb.sv - Wishbone word-by-word block copier; optional ack watchdog via STORAGE_COPY_TIMEOUT_EN
module storage_copy_wb
  import storage_copy_pkg::*;
#(
  parameter int unsigned LEN_W          = 9,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             strobe;
  logic             timeout_hit;

  // Outputs decode straight from registered state so they hold steady while waiting for ack
  assign strobe    = (state_q == RD) || (state_q == WR);
  assign wbm_cyc_o = strobe;
  assign wbm_stb_o = strobe;
  assign wbm_we_o  = (state_q == WR);
  assign wbm_sel_o = strobe ? SEL_ALL : 4'h0;
  assign wbm_adr_o = (state_q == WR) ? dst_q : src_q;
  assign wbm_dat_o = data_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;

`ifdef STORAGE_COPY_TIMEOUT_EN
  storage_copy_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (wb_clk_i),
    .rstn_i   (wb_rst_i),
    .clr_i    (wbm_ack_i),
    .en_i     (strobe),
    .expired_o(timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  // next-state: read a word, idle one cycle, write it, idle one cycle, repeat
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            src_d   = src_adr_i;
            dst_d   = dst_adr_i;
            rem_d   = len_i;
            err_d   = 1'b0;
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        if (wbm_ack_i) begin
          data_d  = wbm_dat_i;
          state_d = GAP_R;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      GAP_R: begin
        state_d = WR;
      end
      WR: begin
        if (wbm_ack_i) begin
          rem_d = rem_q - LEN_W'(1);
          src_d = src_q + WORD_BYTES;
          dst_d = dst_q + WORD_BYTES;
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GAP_W;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      GAP_W: begin
        state_d = RD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_storage_copy_wb.sv
// tb/tb_storage_copy_wb.sv - directed self-checking bench for storage_copy_wb
module tb_storage_copy_wb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [8:0]  len = '0;
  logic        busy, done, err, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;

  int total = 0;
  int bad = 0;

  // responder log
  logic [31:0] wr_adr [0:63];
  logic [31:0] wr_dat [0:63];
  logic [31:0] rd_adr [0:63];
  int nw = 0;
  int nr = 0;
  int scnt = 0;
  int cyc_cycles = 0;
  int busy_cycles = 0;
  logic hold_en = 1'b0;
  int   hold_base = 0;

  storage_copy_wb #(
    .LEN_W(9),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rstn),
    .start_i  (start),
    .src_adr_i(src),
    .dst_adr_i(dst),
    .len_i    (len),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack)
  );

  always #5 clk = ~clk;

  // responder: acks reads in the 3rd strobe cycle, writes in the 2nd
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (cyc === 1'b1 && stb === 1'b1) begin
      cyc_cycles++;
      scnt++;
      if (we === 1'b0) begin
        if (scnt == 1) begin
          rd_adr[nr % 64] = adr;
          nr++;
        end
        dat_i = adr ^ 32'hA5A5_A5A5;
        ack = (scnt == 3) && !(hold_en && (nr - hold_base == 2));
      end else begin
        ack = (scnt == 2);
        if (ack) begin
          wr_adr[nw % 64] = adr;
          wr_dat[nw % 64] = dat_o;
          nw++;
        end
      end
    end else begin
      scnt = 0;
      ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue a start across one edge; returns in cycle 1 after the start edge
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [8:0] l);
    start = 1'b1;
    src = s;
    dst = d;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, input int limit, output int at);
    at = from;
    while (done !== 1'b1 && at < limit) begin
      tick();
      at++;
    end
  endtask

  int at, w0, r0, c0, b0;

  initial begin
    // reset
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_stb", {31'b0, stb}, 32'd0);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_sel", {28'b0, sel}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rstn = 1'b1;
    tick();

    // basic copy of 4 words
    w0 = nw;
    do_start(32'h0020_0000, 32'h0000_0040, 9'd4);
    chk("basic_busy1", {31'b0, busy}, 32'd1);
    chk("basic_cyc1", {31'b0, cyc}, 32'd1);
    chk("basic_we1", {31'b0, we}, 32'd0);
    chk("basic_sel1", {28'b0, sel}, 32'hF);
    chk("basic_adr1", adr, 32'h0020_0000);
    wait_done(1, 100, at);
    chk("basic_done_cycle", at, 32'd28);
    chk("basic_busy_at_done", {31'b0, busy}, 32'd0);
    chk("basic_cyc_at_done", {31'b0, cyc}, 32'd0);
    chk("basic_nw", nw - w0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_wadr%0d", i), wr_adr[(w0 + i) % 64], 32'h40 + 32'(4 * i));
      chk($sformatf("basic_wdat%0d", i), wr_dat[(w0 + i) % 64], (32'h0020_0000 + 32'(4 * i)) ^ 32'hA5A5_A5A5);
    end
    tick();
    chk("basic_done_pulse", {31'b0, done}, 32'd0);

    // zero length
    c0 = cyc_cycles;
    b0 = busy_cycles;
    do_start(32'h0000_1000, 32'h0000_2000, 9'd0);
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    chk("zero_done_pulse", {31'b0, done}, 32'd0);
    chk("zero_no_cyc", cyc_cycles - c0, 32'd0);
    chk("zero_no_busy", busy_cycles - b0, 32'd0);

    // address wrap on source
    w0 = nw;
    r0 = nr;
    do_start(32'hFFFF_FFFC, 32'h0000_0100, 9'd2);
    wait_done(1, 100, at);
    chk("wrap_done_cycle", at, 32'd14);
    chk("wrap_rd0", rd_adr[r0 % 64], 32'hFFFF_FFFC);
    chk("wrap_rd1", rd_adr[(r0 + 1) % 64], 32'h0000_0000);
    chk("wrap_wdat1", wr_dat[(w0 + 1) % 64], 32'hA5A5_A5A5);
    chk("wrap_wadr1", wr_adr[(w0 + 1) % 64], 32'h0000_0104);
    tick();

    // start while busy is ignored
    w0 = nw;
    do_start(32'h0000_1000, 32'h0000_2000, 9'd3);
    repeat (7) tick();
    chk("busy_word2_rd", adr, 32'h0000_1004);
    do_start(32'h0000_7000, 32'h0000_8000, 9'd1);
    wait_done(9, 100, at);
    chk("busy_done_cycle", at, 32'd21);
    repeat (10) tick();
    chk("busy_nw", nw - w0, 32'd3);
    chk("busy_wadr2", wr_adr[(w0 + 2) % 64], 32'h0000_2008);
    chk("busy_wdat2", wr_dat[(w0 + 2) % 64], 32'h0000_1008 ^ 32'hA5A5_A5A5);

    // reset during a write strobe
    w0 = nw;
    do_start(32'h0000_0300, 32'h0000_0400, 9'd2);
    repeat (4) tick();
    chk("rstw_we", {31'b0, we}, 32'd1);
    chk("rstw_cyc", {31'b0, cyc}, 32'd1);
    rstn = 1'b0;
    tick();
    chk("rstw_cyc0", {31'b0, cyc}, 32'd0);
    chk("rstw_stb0", {31'b0, stb}, 32'd0);
    chk("rstw_busy0", {31'b0, busy}, 32'd0);
    chk("rstw_done0", {31'b0, done}, 32'd0);
    chk("rstw_err0", {31'b0, err}, 32'd0);
    chk("rstw_adr0", adr, 32'd0);
    chk("rstw_dat0", dat_o, 32'd0);
    rstn = 1'b1;
    tick();
    do_start(32'h0000_0500, 32'h0000_0600, 9'd1);
    wait_done(1, 100, at);
    chk("rstw_done_cycle", at, 32'd7);
    chk("rstw_nw", nw - w0, 32'd1);
    chk("rstw_wadr", wr_adr[w0 % 64], 32'h0000_0600);
    tick();

`ifdef STORAGE_COPY_TIMEOUT_EN
    // timeout on the 2nd read
    w0 = nw;
    c0 = cyc_cycles;
    hold_base = nr;
    hold_en = 1'b1;
    do_start(32'h0000_0800, 32'h0000_0900, 9'd3);
    wait_done(1, 100, at);
    chk("to_done_cycle", at, 32'd16);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_cyc", {31'b0, cyc}, 32'd0);
    chk("to_busy", {31'b0, busy}, 32'd0);
    chk("to_cyc_cycles", cyc_cycles - c0, 32'd13);
    chk("to_nw", nw - w0, 32'd1);
    hold_en = 1'b0;
    tick();
    chk("to_err_sticky", {31'b0, err}, 32'd1);
    do_start(32'h0000_0A00, 32'h0000_0B00, 9'd1);
    chk("to_err_cleared", {31'b0, err}, 32'd0);
    wait_done(1, 100, at);
    chk("to_next_done_cycle", at, 32'd7);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
